// File: rtl/preg_ready_table_pkg.sv
// Shared backend types for the physical-register ready table.
package preg_ready_table_pkg;

   localparam int unsigned PREG_READY_DEFAULT_PREG_NUM   = 128;
   localparam int unsigned PREG_READY_DEFAULT_SPEC_DEPTH = 2;

   localparam int unsigned PREG_READY_PW =
      $clog2(PREG_READY_DEFAULT_PREG_NUM);
   localparam int unsigned PREG_READY_AW =
      $clog2(PREG_READY_DEFAULT_SPEC_DEPTH + 1);

   typedef logic [PREG_READY_PW-1:0] preg_t;
   typedef logic [PREG_READY_AW-1:0] spec_age_t;

endpackage

// File: rtl/preg_ready_table_onehot_or.sv
// Decodes every port address to a one-hot preg vector and ORs them.
module preg_onehot_or
   import preg_ready_table_pkg::*;
#(
   parameter int unsigned PREG_NUM = PREG_READY_DEFAULT_PREG_NUM,
   parameter int unsigned PORTS    = 1,
   localparam int unsigned PW      = $clog2(PREG_NUM)
) (
   input  logic [PORTS-1:0]         en,
   input  logic [PORTS-1:0][PW-1:0] addr,
   output logic [PREG_NUM-1:0]      hit
);

   always_comb begin
      hit = '0;
      for (int i = 0; i < PREG_NUM; i++) begin
         for (int p = 0; p < PORTS; p++) begin
            if (en[p] && (addr[p] == PW'(i))) hit[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/preg_ready_table.sv
// Physical-register ready table with bypassed queries and walk restore.
// Speculative load wakeup/cancel: define PREG_READY_TABLE_SPEC_WAKEUP_EN.
module preg_ready_table
   import preg_ready_table_pkg::*;
#(
   parameter int unsigned PREG_NUM   = PREG_READY_DEFAULT_PREG_NUM,
   parameter int unsigned DIS_PORTS  = 4,
   parameter int unsigned RD_PORTS   = 8,
   parameter int unsigned WB_PORTS   = 6,
   parameter int unsigned WALK_PORTS = 4,
   parameter int unsigned SPEC_PORTS = 2,
   parameter int unsigned SPEC_DEPTH = PREG_READY_DEFAULT_SPEC_DEPTH,
   localparam int unsigned PW        = $clog2(PREG_NUM)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              redirect,
   input  logic [DIS_PORTS-1:0]              dis_en,
   input  logic [DIS_PORTS-1:0][PW-1:0]      dis_rd,
   input  logic [RD_PORTS-1:0][PW-1:0]       rd_preg,
   output logic [RD_PORTS-1:0]               rd_ready,
   input  logic [WB_PORTS-1:0]               wb_en,
   input  logic [WB_PORTS-1:0]               wb_we,
   input  logic [WB_PORTS-1:0][PW-1:0]       wb_rd,
   input  logic                              walk,
   input  logic [WALK_PORTS-1:0]             walk_en,
   input  logic [WALK_PORTS-1:0]             walk_we,
   input  logic [WALK_PORTS-1:0][PW-1:0]     walk_prd
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
   ,
   input  logic [SPEC_PORTS-1:0]             spec_en,
   input  logic [SPEC_PORTS-1:0][PW-1:0]     spec_rd,
   input  logic [SPEC_PORTS-1:0]             cancel_en,
   input  logic [SPEC_PORTS-1:0][PW-1:0]     cancel_rd,
   output logic [RD_PORTS-1:0]               rd_spec
`endif
);

   logic [PREG_NUM-1:0] ready_q;
   logic [PREG_NUM-1:0] ready_d;
   logic [PREG_NUM-1:0] rdy_vec;
   logic [PREG_NUM-1:0] dis_hit;
   logic [PREG_NUM-1:0] wb_hit;
   logic [PREG_NUM-1:0] walk_hit;
   logic [PREG_NUM-1:0] conf;

   logic [DIS_PORTS-1:0]  dis_act;
   logic [WB_PORTS-1:0]   wb_act;
   logic [WALK_PORTS-1:0] walk_act;

   assign dis_act  = dis_en & ~{DIS_PORTS{redirect}};
   assign wb_act   = wb_en & wb_we;
   assign walk_act = {WALK_PORTS{walk}} & walk_en & walk_we;

   preg_onehot_or #(.PREG_NUM(PREG_NUM), .PORTS(DIS_PORTS)) u_dis (
      .en   (dis_act),
      .addr (dis_rd),
      .hit  (dis_hit)
   );

   preg_onehot_or #(.PREG_NUM(PREG_NUM), .PORTS(WB_PORTS)) u_wb (
      .en   (wb_act),
      .addr (wb_rd),
      .hit  (wb_hit)
   );

   preg_onehot_or #(.PREG_NUM(PREG_NUM), .PORTS(WALK_PORTS)) u_walk (
      .en   (walk_act),
      .addr (walk_prd),
      .hit  (walk_hit)
   );

   assign conf = wb_hit | walk_hit;

`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
   localparam int unsigned AW = $clog2(SPEC_DEPTH + 1);

   logic [PREG_NUM-1:0] spec_hit;
   logic [PREG_NUM-1:0] cancel_hit;
   logic [PREG_NUM-1:0] kill;
   logic [PREG_NUM-1:0] spec_q;
   logic [PREG_NUM-1:0] spec_d;
   logic [PREG_NUM-1:0] spc_vec;
   logic [AW-1:0]       age_q [PREG_NUM];
   logic [AW-1:0]       age_d [PREG_NUM];

   preg_onehot_or #(.PREG_NUM(PREG_NUM), .PORTS(SPEC_PORTS)) u_spec (
      .en   (spec_en),
      .addr (spec_rd),
      .hit  (spec_hit)
   );

   preg_onehot_or #(.PREG_NUM(PREG_NUM), .PORTS(SPEC_PORTS)) u_cancel (
      .en   (cancel_en),
      .addr (cancel_rd),
      .hit  (cancel_hit)
   );

   // A cancel only bites while a speculative wakeup is live and unconfirmed
   assign kill    = cancel_hit & (spec_q | spec_hit) & ~conf;
   assign ready_d = (ready_q | conf | spec_hit) & ~kill & ~dis_hit;
   assign rdy_vec = (ready_q & ~kill) | conf | (spec_hit & ~kill);
   assign spc_vec = (spec_q | spec_hit) & ~kill & ~conf;

   always_comb begin
      for (int i = 0; i < PREG_NUM; i++) begin
         spec_d[i] = 1'b0;
         age_d[i]  = '0;
         if (!(dis_hit[i] || conf[i] || kill[i])) begin
            if (spec_hit[i]) begin
               spec_d[i] = 1'b1;
               age_d[i]  = AW'(SPEC_DEPTH);
            end else if (spec_q[i] && (age_q[i] != AW'(1))) begin
               spec_d[i] = 1'b1;
               age_d[i]  = age_q[i] - AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spec_q <= '0;
         for (int i = 0; i < PREG_NUM; i++) age_q[i] <= '0;
      end else begin
         spec_q <= spec_d;
         for (int i = 0; i < PREG_NUM; i++) age_q[i] <= age_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < RD_PORTS; i++) rd_spec[i] = spc_vec[rd_preg[i]];
   end
`else
   logic unused_spec_cfg;

   assign unused_spec_cfg = ^{32'(SPEC_DEPTH), 32'(SPEC_PORTS)};
   assign ready_d = (ready_q | conf) & ~dis_hit;
   assign rdy_vec = ready_q | conf;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ready_q <= '1;
      else      ready_q <= ready_d;
   end

   always_comb begin
      for (int i = 0; i < RD_PORTS; i++) rd_ready[i] = rdy_vec[rd_preg[i]];
   end

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed-vector bench for preg_ready_table (default parameters).
module tb_preg_ready_table;
   import preg_ready_table_pkg::*;

   logic             clk;
   logic             rst;
   logic             redirect;
   logic [3:0]       dis_en;
   logic [3:0][6:0]  dis_rd;
   logic [7:0][6:0]  rd_preg;
   logic [7:0]       rd_ready;
   logic [5:0]       wb_en;
   logic [5:0]       wb_we;
   logic [5:0][6:0]  wb_rd;
   logic             walk;
   logic [3:0]       walk_en;
   logic [3:0]       walk_we;
   logic [3:0][6:0]  walk_prd;
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
   logic [1:0]       spec_en;
   logic [1:0][6:0]  spec_rd;
   logic [1:0]       cancel_en;
   logic [1:0][6:0]  cancel_rd;
   logic [7:0]       rd_spec;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   preg_ready_table dut (
      .clk      (clk),
      .rst      (rst),
      .redirect (redirect),
      .dis_en   (dis_en),
      .dis_rd   (dis_rd),
      .rd_preg  (rd_preg),
      .rd_ready (rd_ready),
      .wb_en    (wb_en),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .walk     (walk),
      .walk_en  (walk_en),
      .walk_we  (walk_we),
      .walk_prd (walk_prd)
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
      ,
      .spec_en   (spec_en),
      .spec_rd   (spec_rd),
      .cancel_en (cancel_en),
      .cancel_rd (cancel_rd),
      .rd_spec   (rd_spec)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      redirect = 1'b0;
      dis_en   = '0;
      dis_rd   = '0;
      wb_en    = '0;
      wb_we    = '0;
      wb_rd    = '0;
      walk     = 1'b0;
      walk_en  = '0;
      walk_we  = '0;
      walk_prd = '0;
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
      spec_en   = '0;
      spec_rd   = '0;
      cancel_en = '0;
      cancel_rd = '0;
`endif
   endtask

   // Apply current inputs across one rising edge, then return to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic dispatch(input preg_t p);
      dis_en[0] = 1'b1;
      dis_rd[0] = p;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      rd_preg    = '0;
      rd_preg[0] = 7'd0;
      rd_preg[1] = 7'd5;
      rd_preg[2] = 7'd127;
      #12;
      if (rd_ready[2:0] !== 3'b111) begin
         n_bad++;
         $display("FAIL reset_ready_during got=%b want=111", rd_ready[2:0]);
      end
      n_cmp++;
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
      if (rd_spec[2:0] !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_spec_during got=%b want=000", rd_spec[2:0]);
      end
      n_cmp++;
`endif
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      if (rd_ready !== 8'hff) begin
         n_bad++;
         $display("FAIL reset_ready_after got=%h want=ff", rd_ready);
      end
      n_cmp++;
   endtask

   task automatic test_dispatch();
      dispatch(7'd5);
      if (rd_ready[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL dis_clear got=%b want=0", rd_ready[1]);
      end
      n_cmp++;
      if (rd_ready[0] !== 1'b1 || rd_ready[2] !== 1'b1) begin
         n_bad++;
         $display("FAIL dis_others got=%b%b want=11", rd_ready[0], rd_ready[2]);
      end
      n_cmp++;
      // two ports hitting the same preg merge into one clear
      dis_en = 4'b0011;
      dis_rd[0] = 7'd30;
      dis_rd[1] = 7'd30;
      rd_preg[3] = 7'd30;
      tick();
      if (rd_ready[3] !== 1'b0) begin
         n_bad++;
         $display("FAIL dis_duplicate got=%b want=0", rd_ready[3]);
      end
      n_cmp++;
   endtask

   task automatic test_redirect();
      wb_en[2] = 1'b1;
      wb_we[2] = 1'b1;
      wb_rd[2] = 7'd5;
      tick();
      redirect  = 1'b1;
      dis_en[1] = 1'b1;
      dis_rd[1] = 7'd5;
      tick();
      if (rd_ready[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL redirect_suppress got=%b want=1", rd_ready[1]);
      end
      n_cmp++;
      dis_en[0] = 1'b1;
      dis_rd[0] = 7'd5;
      wb_en[5]  = 1'b1;
      wb_we[5]  = 1'b1;
      wb_rd[5]  = 7'd5;
      tick();
      if (rd_ready[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL dis_beats_wb got=%b want=0", rd_ready[1]);
      end
      n_cmp++;
   endtask

   task automatic test_wb_bypass();
      rd_preg[4] = 7'd9;
      dispatch(7'd9);
      wb_en[0] = 1'b1;
      wb_we[0] = 1'b0;
      wb_rd[0] = 7'd9;
      #1;
      if (rd_ready[4] !== 1'b0) begin
         n_bad++;
         $display("FAIL wb_no_we got=%b want=0", rd_ready[4]);
      end
      n_cmp++;
      wb_we[0] = 1'b1;
      #1;
      if (rd_ready[4] !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_bypass got=%b want=1", rd_ready[4]);
      end
      n_cmp++;
      tick();
      if (rd_ready[4] !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_hold1 got=%b want=1", rd_ready[4]);
      end
      n_cmp++;
      tick();
      if (rd_ready[4] !== 1'b1) begin
         n_bad++;
         $display("FAIL wb_hold2 got=%b want=1", rd_ready[4]);
      end
      n_cmp++;
   endtask

   task automatic test_walk();
      rd_preg[5] = 7'd20;
      dispatch(7'd20);
      walk        = 1'b1;
      walk_en[3]  = 1'b1;
      walk_we[3]  = 1'b0;
      walk_prd[3] = 7'd20;
      tick();
      if (rd_ready[5] !== 1'b0) begin
         n_bad++;
         $display("FAIL walk_no_we got=%b want=0", rd_ready[5]);
      end
      n_cmp++;
      walk        = 1'b0;
      walk_en[3]  = 1'b1;
      walk_we[3]  = 1'b1;
      walk_prd[3] = 7'd20;
      tick();
      if (rd_ready[5] !== 1'b0) begin
         n_bad++;
         $display("FAIL walk_gated got=%b want=0", rd_ready[5]);
      end
      n_cmp++;
      walk        = 1'b1;
      walk_en[3]  = 1'b1;
      walk_we[3]  = 1'b1;
      walk_prd[3] = 7'd20;
      #1;
      if (rd_ready[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL walk_bypass got=%b want=1", rd_ready[5]);
      end
      n_cmp++;
      tick();
      if (rd_ready[5] !== 1'b1) begin
         n_bad++;
         $display("FAIL walk_restore got=%b want=1", rd_ready[5]);
      end
      n_cmp++;
   endtask

`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
   task automatic test_spec_cancel();
      rd_preg[6] = 7'd9;
      dispatch(7'd9);
      for (int t = 0; t < 3; t++) begin
         if (t == 0) begin
            spec_en[1] = 1'b1;
            spec_rd[1] = 7'd9;
         end
         #1;
         if ({rd_ready[6], rd_spec[6]} !== 2'b11) begin
            n_bad++;
            $display("FAIL spec_window t=%0d got=%b%b want=11",
                     t, rd_ready[6], rd_spec[6]);
         end
         n_cmp++;
         if (t < 2) tick();
      end
      cancel_en[0] = 1'b1;
      cancel_rd[0] = 7'd9;
      #1;
      if ({rd_ready[6], rd_spec[6]} !== 2'b00) begin
         n_bad++;
         $display("FAIL cancel_comb got=%b%b want=00", rd_ready[6], rd_spec[6]);
      end
      n_cmp++;
      tick();
      if ({rd_ready[6], rd_spec[6]} !== 2'b00) begin
         n_bad++;
         $display("FAIL cancel_state got=%b%b want=00", rd_ready[6], rd_spec[6]);
      end
      n_cmp++;
   endtask

   task automatic test_spec_expire();
      dispatch(7'd9);
      spec_en[0] = 1'b1;
      spec_rd[0] = 7'd9;
      tick();
      tick();
      tick();
      if ({rd_ready[6], rd_spec[6]} !== 2'b10) begin
         n_bad++;
         $display("FAIL spec_expire got=%b%b want=10", rd_ready[6], rd_spec[6]);
      end
      n_cmp++;
      cancel_en[1] = 1'b1;
      cancel_rd[1] = 7'd9;
      #1;
      if (rd_ready[6] !== 1'b1) begin
         n_bad++;
         $display("FAIL late_cancel_comb got=%b want=1", rd_ready[6]);
      end
      n_cmp++;
      tick();
      if (rd_ready[6] !== 1'b1) begin
         n_bad++;
         $display("FAIL late_cancel_state got=%b want=1", rd_ready[6]);
      end
      n_cmp++;
   endtask

   task automatic test_spec_confirm();
      rd_preg[7] = 7'd12;
      dispatch(7'd12);
      spec_en[0]   = 1'b1;
      spec_rd[0]   = 7'd12;
      cancel_en[0] = 1'b1;
      cancel_rd[0] = 7'd12;
      wb_en[1]     = 1'b1;
      wb_we[1]     = 1'b1;
      wb_rd[1]     = 7'd12;
      #1;
      if ({rd_ready[7], rd_spec[7]} !== 2'b10) begin
         n_bad++;
         $display("FAIL confirm_comb got=%b%b want=10", rd_ready[7], rd_spec[7]);
      end
      n_cmp++;
      tick();
      if ({rd_ready[7], rd_spec[7]} !== 2'b10) begin
         n_bad++;
         $display("FAIL confirm_state got=%b%b want=10", rd_ready[7], rd_spec[7]);
      end
      n_cmp++;
   endtask
`endif

   initial begin
      test_reset();
      test_dispatch();
      test_redirect();
      test_wb_bypass();
      test_walk();
`ifdef PREG_READY_TABLE_SPEC_WAKEUP_EN
      test_spec_cancel();
      test_spec_expire();
      test_spec_confirm();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
